// File: rtl/unidad_control_riesgos.sv
// Hazard controller beside the ID stage: load-use bubbles, mult/div scheduling
// with HI/LO interlock, branch flush and a saturating stall-cycle counter.
module unidad_control_riesgos #(
  parameter int MULDIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  if_id_rs,
  input  logic [4:0]  if_id_rt,
  input  logic        id_uses_rt,
  input  logic        id_ex_memRead,
  input  logic [4:0]  id_ex_rt,
  input  logic        id_is_muldiv,
  input  logic        id_reads_hilo,
  input  logic        branch_taken,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        id_ex_bubble,
  output logic        if_id_flush,
  output logic        muldiv_start,
  output logic        muldiv_busy,
  output logic [15:0] stall_cycles
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [7:0] CNT_INIT = 8'(MULDIV_CYCLES - 1);

  logic [0:0] state;
  logic [7:0] cnt;
  logic       ld_haz, md_haz, stall, start;

  always_comb begin
    ld_haz = id_ex_memRead && (id_ex_rt != 5'd0) &&
             ((id_ex_rt == if_id_rs) || (id_uses_rt && (id_ex_rt == if_id_rt)));
    md_haz = (state == BUSY) && (id_is_muldiv || id_reads_hilo);
    stall  = ld_haz || md_haz;
    // A load-use hazard blocks issue, so the start is retried next cycle.
    start  = (state == RUN) && id_is_muldiv && !ld_haz;
  end

  always_comb begin
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
      muldiv_start = 1'b0;
      muldiv_busy  = 1'b0;
    end else begin
      pc_write     = !stall;
      if_id_write  = !stall;
      id_ex_bubble = stall;
      if_id_flush  = branch_taken && !stall;
      muldiv_start = start;
      muldiv_busy  = (state == BUSY);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      cnt          <= 8'd0;
      stall_cycles <= 16'd0;
    end else begin
      if (stall && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
      // cnt counts remaining BUSY cycles after the current one.
      case (state)
        RUN: if (start) begin
          cnt   <= CNT_INIT;
          state <= BUSY;
        end
        BUSY: if (cnt == 8'd0) state <= RUN;
              else             cnt   <= cnt - 8'd1;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_unidad_control_riesgos.sv
// Self-checking bench for unidad_control_riesgos: directed scenarios plus
// random traffic against a remaining-cycles reference model.
module tb_unidad_control_riesgos;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  if_id_rs, if_id_rt, id_ex_rt;
  logic        id_uses_rt, id_ex_memRead, id_is_muldiv, id_reads_hilo, branch_taken;
  logic        pc_write, if_id_write, id_ex_bubble, if_id_flush, muldiv_start, muldiv_busy;
  logic [15:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  // Reference state: cycles of busy left, and the stall count as an integer.
  int         busy_left = 0;
  int         stall_ref = 0;
  logic [5:0] exp_o;

  unidad_control_riesgos #(.MULDIV_CYCLES(N)) dut (
    .clk(clk), .reset(reset),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .id_uses_rt(id_uses_rt),
    .id_ex_memRead(id_ex_memRead), .id_ex_rt(id_ex_rt),
    .id_is_muldiv(id_is_muldiv), .id_reads_hilo(id_reads_hilo),
    .branch_taken(branch_taken),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .muldiv_start(muldiv_start), .muldiv_busy(muldiv_busy),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] obs();
    return {pc_write, if_id_write, id_ex_bubble, if_id_flush, muldiv_start, muldiv_busy};
  endfunction

  function automatic bit ref_ld();
    return id_ex_memRead && id_ex_rt != 0 &&
           (id_ex_rt == if_id_rs || (id_uses_rt && id_ex_rt == if_id_rt));
  endfunction

  function automatic bit ref_stall();
    return ref_ld() || (busy_left > 0 && (id_is_muldiv || id_reads_hilo));
  endfunction

  function automatic bit ref_start();
    return busy_left == 0 && id_is_muldiv && !ref_ld();
  endfunction

  function automatic void model_eval();
    bit st;
    st = ref_stall();
    if (reset) exp_o = 6'b001100;
    else       exp_o = {!st, !st, st, branch_taken && !st, ref_start(), busy_left > 0};
  endfunction

  task automatic advance();
    bit st, sr;
    @(posedge clk);
    st = ref_stall();
    sr = ref_start();
    if (reset) begin
      busy_left = 0;
      stall_ref = 0;
    end else begin
      if (st && stall_ref < 65535) stall_ref++;
      if (sr) busy_left = N;
      else if (busy_left > 0) busy_left--;
    end
    #1;
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic mr, input logic [4:0] exrt, input logic md,
                        input logic hl, input logic bt);
    if_id_rs = rs; if_id_rt = rt; id_uses_rt = urt; id_ex_memRead = mr;
    id_ex_rt = exrt; id_is_muldiv = md; id_reads_hilo = hl; branch_taken = bt;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(5, 7, 1, 1, 5, 1, 1, 1);
    @(negedge clk);
    total++;
    if (obs() !== 6'b001100) begin bad++; $display("FAIL reset_outs: got %b want 001100", obs()); end
    advance();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (stall_cycles !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", stall_cycles); end
    reset = 1'b0;
    advance();
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(5, 0, 0, 1, 5, 0, 0, 0);
    @(negedge clk); model_eval();
    total++;
    if (obs() !== 6'b001000) begin bad++; $display("FAIL ld_rs: got %b want 001000", obs()); end
    advance();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (stall_cycles !== 16'd1) begin bad++; $display("FAIL ld_rs_cnt: got %0d want 1", stall_cycles); end
    advance();
    set_in(0, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    total++;
    if (obs() !== 6'b110000) begin bad++; $display("FAIL ld_r0: got %b want 110000", obs()); end
    advance();
    set_in(1, 7, 0, 1, 7, 0, 0, 0);
    @(negedge clk);
    total++;
    if (obs() !== 6'b110000) begin bad++; $display("FAIL ld_rt_unused: got %b want 110000", obs()); end
    advance();
    set_in(1, 7, 1, 1, 7, 0, 0, 0);
    @(negedge clk);
    total++;
    if (obs() !== 6'b001000) begin bad++; $display("FAIL ld_rt_used: got %b want 001000", obs()); end
    advance();
  endtask

  task automatic test_muldiv();
    logic [5:0] want;
    do_reset();
    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    total++;
    if (obs() !== 6'b110010) begin bad++; $display("FAIL md_start: got %b want 110010", obs()); end
    advance();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= N + 1; k++) begin
      @(negedge clk);
      want = (k <= N) ? 6'b001001 : 6'b110000;
      total++;
      if (obs() !== want) begin bad++; $display("FAIL md_mflo t+%0d: got %b want %b", k, obs(), want); end
      advance();
    end
    @(negedge clk);
    total++;
    if (stall_cycles !== 16'd4) begin bad++; $display("FAIL md_cnt: got %0d want 4", stall_cycles); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] want;
    do_reset();
    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k <= N + 1; k++) begin
      @(negedge clk);
      if (k == 0 || k == N + 1) want = 6'b110010;
      else                      want = 6'b001001;
      total++;
      if (obs() !== want) begin bad++; $display("FAIL b2b t+%0d: got %b want %b", k, obs(), want); end
      advance();
    end
  endtask

  task automatic test_branch();
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    total++;
    if (obs() !== 6'b110100) begin bad++; $display("FAIL br_alone: got %b want 110100", obs()); end
    advance();
    set_in(3, 0, 0, 1, 3, 0, 0, 1);
    @(negedge clk);
    total++;
    if (obs() !== 6'b001000) begin bad++; $display("FAIL br_stall: got %b want 001000", obs()); end
    advance();
  endtask

  task automatic test_reset_busy();
    do_reset();
    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    advance();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    advance();
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (obs() !== 6'b001100) begin bad++; $display("FAIL rb_forced: got %b want 001100", obs()); end
    advance();
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    total++;
    if (obs() !== 6'b110010 || stall_cycles !== 16'd0)
      begin bad++; $display("FAIL rb_restart: got %b/%0d want 110010/0", obs(), stall_cycles); end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
             ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), 1'($urandom));
      @(negedge clk); model_eval();
      total++;
      if (obs() !== exp_o || stall_cycles !== 16'(stall_ref))
        begin bad++; $display("FAIL rand %0d: got %b/%0d want %b/%0d", i, obs(), stall_cycles, exp_o, stall_ref); end
      advance();
    end
    reset = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    set_in(9, 0, 0, 1, 9, 0, 0, 0);
    repeat (70000) advance();
    @(negedge clk);
    total++;
    if (stall_cycles !== 16'hFFFF || stall_ref != 65535)
      begin bad++; $display("FAIL sat: got %h want ffff", stall_cycles); end
    advance();
    @(negedge clk);
    total++;
    if (stall_cycles !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %h want ffff", stall_cycles); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_muldiv();
    test_back_to_back();
    test_branch();
    test_reset_busy();
    test_random();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
